ysyx_220066_mem_arbiter: RTL and testbench

- Parametrised N-channel memory-port arbiter for the ysyx_220066 core.
- Merges the icache refill, dcache read and dcache write/writeback channels onto a single downstream memory port.
- Grants round-robin and holds the grant for the whole transaction. Each requestor sees the existing req/ready/err handshake with registered response data.
- Adds a programmable timeout that converts a hung memory transaction into an error on the requesting channel.

---
 rtl/ysyx_220066_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ysyx_220066_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220066_mem_arbiter.sv
// N-channel round-robin arbiter merging cache refill/write channels onto one memory port.
// The grant is held for the whole transaction; a hung transaction is aborted with an error.
module ysyx_220066_mem_arbiter #(
    parameter int unsigned NCH     = 3,
    parameter int unsigned LINE_W  = 512,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_wr,
    input  logic [NCH-1:0]        ch_burst,
    input  logic [3*NCH-1:0]      ch_len,
    input  logic [8*NCH-1:0]      ch_mask,
    input  logic [ADDR_W*NCH-1:0] ch_addr,
    input  logic [LINE_W*NCH-1:0] ch_wdata,
    output logic [NCH-1:0]        ch_ready,
    output logic [NCH-1:0]        ch_err,
    output logic [LINE_W-1:0]     ch_rdata,
    output logic                  m_req,
    output logic                  m_wr,
    output logic                  m_burst,
    output logic [2:0]            m_len,
    output logic [7:0]            m_mask,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [LINE_W-1:0]     m_wdata,
    input  logic                  m_ready,
    input  logic                  m_err,
    input  logic [LINE_W-1:0]     m_rdata
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       grant_q, grant_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                m_req_q, m_req_d;
    logic                m_wr_q, m_wr_d;
    logic                m_burst_q, m_burst_d;
    logic [2:0]          m_len_q, m_len_d;
    logic [7:0]          m_mask_q, m_mask_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [LINE_W-1:0]   m_wdata_q, m_wdata_d;
    logic [NCH-1:0]      ch_ready_q, ch_ready_d;
    logic [NCH-1:0]      ch_err_q, ch_err_d;
    logic [LINE_W-1:0]   ch_rdata_q, ch_rdata_d;

    logic [2:0]          len_a   [NCH];
    logic [7:0]          mask_a  [NCH];
    logic [ADDR_W-1:0]   addr_a  [NCH];
    logic [LINE_W-1:0]   wdata_a [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign len_a[k]   = ch_len[3*k +: 3];
        assign mask_a[k]  = ch_mask[8*k +: 8];
        assign addr_a[k]  = ch_addr[ADDR_W*k +: ADDR_W];
        assign wdata_a[k] = ch_wdata[LINE_W*k +: LINE_W];
    end

    // Round-robin scan starting at the pointer, wrapping modulo NCH.
    logic          found;
    logic [PW-1:0] win;
    int unsigned   scan;

    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            scan = 32'(ptr_q) + i;
            if (scan >= NCH) scan = scan - NCH;
            if (!found && ch_req[PW'(scan)]) begin
                found = 1'b1;
                win   = PW'(scan);
            end
        end
    end

    logic timeout_hit;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        m_req_d    = m_req_q;
        m_wr_d     = m_wr_q;
        m_burst_d  = m_burst_q;
        m_len_d    = m_len_q;
        m_mask_d   = m_mask_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        ch_rdata_d = ch_rdata_q;
        ch_ready_d = '0;
        ch_err_d   = '0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d   = win;
                    m_wr_d    = ch_wr[win];
                    m_burst_d = ch_burst[win];
                    m_len_d   = len_a[win];
                    m_mask_d  = mask_a[win];
                    m_addr_d  = addr_a[win];
                    m_wdata_d = wdata_a[win];
                    m_req_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (m_ready) begin
                    m_req_d = 1'b0;
                    state_d = StResp;
                    if (m_err) begin
                        ch_err_d[grant_q] = 1'b1;
                        ch_rdata_d        = '0;
                    end else begin
                        ch_ready_d[grant_q] = 1'b1;
                        // Writes leave the shared read-data register untouched.
                        if (!m_wr_q) ch_rdata_d = m_rdata;
                    end
                end else if (timeout_hit) begin
                    ch_err_d[grant_q] = 1'b1;
                    ch_rdata_d        = '0;
                    m_req_d           = 1'b0;
                    state_d           = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                ptr_d   = (grant_q == PW'(NCH - 1)) ? '0 : grant_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            m_req_q    <= 1'b0;
            m_wr_q     <= 1'b0;
            m_burst_q  <= 1'b0;
            m_len_q    <= '0;
            m_mask_q   <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            ch_ready_q <= '0;
            ch_err_q   <= '0;
            ch_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            m_req_q    <= m_req_d;
            m_wr_q     <= m_wr_d;
            m_burst_q  <= m_burst_d;
            m_len_q    <= m_len_d;
            m_mask_q   <= m_mask_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            ch_ready_q <= ch_ready_d;
            ch_err_q   <= ch_err_d;
            ch_rdata_q <= ch_rdata_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_wr     = m_wr_q;
    assign m_burst  = m_burst_q;
    assign m_len    = m_len_q;
    assign m_mask   = m_mask_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign ch_ready = ch_ready_q;
    assign ch_err   = ch_err_q;
    assign ch_rdata = ch_rdata_q;

endmodule

// File: tb/tb_ysyx_220066_mem_arbiter.sv
// Directed bench for the memory arbiter: read, round-robin order, write fields,
// timeout abort, downstream error and mid-transaction reset.
module tb_ysyx_220066_mem_arbiter;

    localparam int NCH = 3;
    localparam int LW  = 512;
    localparam int AW  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_req, ch_wr, ch_burst;
    logic [3*NCH-1:0]  ch_len;
    logic [8*NCH-1:0]  ch_mask;
    logic [AW*NCH-1:0] ch_addr;
    logic [LW*NCH-1:0] ch_wdata;
    logic [NCH-1:0]    ch_ready, ch_err;
    logic [LW-1:0]     ch_rdata;
    logic              m_req, m_wr, m_burst;
    logic [2:0]        m_len;
    logic [7:0]        m_mask;
    logic [AW-1:0]     m_addr;
    logic [LW-1:0]     m_wdata;
    logic              m_ready, m_err;
    logic [LW-1:0]     m_rdata;

    int vectors = 0;
    int errors  = 0;
    logic [LW-1:0] last_rd;

    ysyx_220066_mem_arbiter #(
        .NCH(NCH), .LINE_W(LW), .ADDR_W(AW), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_burst(ch_burst), .ch_len(ch_len),
        .ch_mask(ch_mask), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_ready(ch_ready), .ch_err(ch_err), .ch_rdata(ch_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_burst(m_burst), .m_len(m_len),
        .m_mask(m_mask), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_err(m_err), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle; outputs are sampled 1ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ch_req = '0; ch_wr = '0; ch_burst = '0; ch_len = '0; ch_mask = '0;
        ch_addr = '0; ch_wdata = '0; m_ready = 1'b0; m_err = 1'b0; m_rdata = '0;
        tick; tick;
        vectors++;
        if ({m_req, ch_ready, ch_err} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0", {m_req, ch_ready, ch_err});
        end
        vectors++;
        if ({m_wr, m_burst, m_len, m_mask, m_addr} !== '0 || m_wdata !== '0 || ch_rdata !== '0) begin
            errors++; $display("FAIL reset_fields: got addr %h len %h mask %h", m_addr, m_len, m_mask);
        end
        rst = 1'b0;
    endtask

    task automatic test_read;
        logic [LW-1:0] pat;
        pat = {64{8'hA5}};
        ch_addr[AW-1:0] = 64'h8000_0040;
        ch_wr[0] = 1'b0;
        ch_req[0] = 1'b1;
        tick;
        vectors++;
        if (m_req !== 1'b1 || m_addr !== 64'h8000_0040 || m_wr !== 1'b0) begin
            errors++; $display("FAIL read_issue: got req %b addr %h wr %b want 1 80000040 0",
                               m_req, m_addr, m_wr);
        end
        tick;
        vectors++;
        if (ch_ready !== 3'b000 || m_req !== 1'b1) begin
            errors++; $display("FAIL read_wait: got ready %b req %b want 000 1", ch_ready, m_req);
        end
        m_ready = 1'b1; m_rdata = pat;
        tick;
        m_ready = 1'b0; m_rdata = '0; ch_req[0] = 1'b0;
        last_rd = pat;
        vectors++;
        if (ch_ready !== 3'b001 || ch_rdata !== pat || m_req !== 1'b0) begin
            errors++; $display("FAIL read_resp: got ready %b req %b rdata %h want 001 0 a5..",
                               ch_ready, m_req, ch_rdata);
        end
        tick;
        vectors++;
        if (ch_ready !== 3'b000) begin
            errors++; $display("FAIL read_pulse: got %b want 000", ch_ready);
        end
    endtask

    task automatic test_round_robin;
        int order [5] = '{0, 1, 2, 0, 2};
        logic [AW-1:0] ea;
        logic [LW-1:0] rd;
        rst = 1'b1; tick; rst = 1'b0;
        for (int k = 0; k < NCH; k++) ch_addr[k*AW +: AW] = 64'(k + 1) << 12;
        ch_wr = '0;
        ch_req = 3'b111;
        for (int t = 0; t < 5; t++) begin
            if (t == 3) ch_req = 3'b101;
            ea = 64'(order[t] + 1) << 12;
            tick;
            vectors++;
            if (m_req !== 1'b1 || m_addr !== ea) begin
                errors++; $display("FAIL rr_grant%0d: got req %b addr %h want 1 %h", t, m_req, m_addr, ea);
            end
            rd = {16{32'hC0DE_0000 | 32'(t)}};
            m_ready = 1'b1; m_rdata = rd;
            tick;
            m_ready = 1'b0; m_rdata = '0;
            last_rd = rd;
            vectors++;
            if (ch_ready !== (3'b001 << order[t]) || ch_rdata !== rd) begin
                errors++; $display("FAIL rr_ready%0d: got %b want %b", t, ch_ready, 3'b001 << order[t]);
            end
            ch_req[order[t]] = 1'b0;
            tick;
        end
    endtask

    task automatic test_write;
        logic [LW-1:0] wd;
        wd = {64{8'h5A}};
        ch_wr[2] = 1'b1; ch_burst[2] = 1'b1; ch_len[8:6] = 3'd3; ch_mask[23:16] = 8'h0F;
        ch_addr[3*AW-1:2*AW] = 64'hA000_0008; ch_wdata[3*LW-1:2*LW] = wd;
        ch_req[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            vectors++;
            if ({m_req, m_wr, m_burst, m_len, m_mask} !== {1'b1, 1'b1, 1'b1, 3'd3, 8'h0F} ||
                m_addr !== 64'hA000_0008 || m_wdata !== wd) begin
                errors++; $display("FAIL write_fields%0d: got req %b wr %b burst %b len %0d mask %h addr %h",
                                   c, m_req, m_wr, m_burst, m_len, m_mask, m_addr);
            end
        end
        m_ready = 1'b1; m_rdata = {16{32'hDEAD_BEEF}};
        tick;
        m_ready = 1'b0; m_rdata = '0; ch_req[2] = 1'b0; ch_wr[2] = 1'b0; ch_burst[2] = 1'b0;
        vectors++;
        if (ch_ready !== 3'b100 || ch_err !== 3'b000 || ch_rdata !== last_rd) begin
            errors++; $display("FAIL write_resp: got ready %b err %b rdata %h want 100 000 %h",
                               ch_ready, ch_err, ch_rdata, last_rd);
        end
        tick;
    endtask

    task automatic test_timeout;
        int bad;
        ch_addr[2*AW-1:AW] = 64'h9000_0000;
        ch_req[1] = 1'b1;
        tick;
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            if (m_req !== 1'b1 || ch_err !== 3'b000) bad++;
            if (c < 15) tick;
        end
        vectors++;
        if (bad != 0) begin
            errors++; $display("FAIL timeout_wait: got %0d bad WAIT cycles want 0", bad);
        end
        tick;
        ch_req[1] = 1'b0;
        vectors++;
        if (m_req !== 1'b0 || ch_err !== 3'b010 || ch_ready !== 3'b000) begin
            errors++; $display("FAIL timeout_err: got req %b err %b ready %b want 0 010 000",
                               m_req, ch_err, ch_ready);
        end
        tick;
        vectors++;
        if (ch_err !== 3'b000) begin
            errors++; $display("FAIL timeout_once: got %b want 000", ch_err);
        end
        tick;
        m_ready = 1'b1; m_rdata = {16{32'h1234_5678}};
        tick;
        m_ready = 1'b0; m_rdata = '0;
        tick;
        vectors++;
        if (ch_ready !== 3'b000 || ch_err !== 3'b000 || m_req !== 1'b0) begin
            errors++; $display("FAIL timeout_stray: got ready %b err %b req %b want 000 000 0",
                               ch_ready, ch_err, m_req);
        end
    endtask

    task automatic test_error;
        ch_req[0] = 1'b1;
        tick;
        vectors++;
        if (m_req !== 1'b1 || m_addr !== 64'h1000) begin
            errors++; $display("FAIL err_issue: got req %b addr %h want 1 1000", m_req, m_addr);
        end
        m_ready = 1'b1; m_err = 1'b1; m_rdata = {16{32'hFFFF_0001}};
        tick;
        m_ready = 1'b0; m_err = 1'b0; m_rdata = '0; ch_req[0] = 1'b0;
        vectors++;
        if (ch_err !== 3'b001 || ch_ready !== 3'b000 || ch_rdata !== '0) begin
            errors++; $display("FAIL err_resp: got err %b ready %b rdata %h want 001 000 0",
                               ch_err, ch_ready, ch_rdata);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        // Pointer sits at 1 here, so a surviving pointer would grant ch1 first.
        ch_req[1] = 1'b1;
        tick;
        vectors++;
        if (m_req !== 1'b1 || m_addr !== 64'h9000_0000) begin
            errors++; $display("FAIL rstmid_issue: got req %b addr %h want 1 90000000", m_req, m_addr);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vectors++;
        if (m_req !== 1'b0 || ch_ready !== 3'b000 || ch_err !== 3'b000) begin
            errors++; $display("FAIL rstmid_drop: got req %b ready %b err %b want 0 000 000",
                               m_req, ch_ready, ch_err);
        end
        ch_req = 3'b111;
        tick;
        vectors++;
        if (m_req !== 1'b1 || m_addr !== 64'h1000 || ch_ready !== 3'b000 || ch_err !== 3'b000) begin
            errors++; $display("FAIL rstmid_regrant: got req %b addr %h ready %b want 1 1000 000",
                               m_req, m_addr, ch_ready);
        end
        ch_req = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        last_rd = '0;
        test_reset;
        test_read;
        test_round_robin;
        test_write;
        test_timeout;
        test_error;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
